prefix_addsub_pipe: RTL and testbench

- Parametrised, pipelined parallel-prefix adder/subtractor for the ALU datapath; the generalised successor to the fixed 16-bit combinational prefix adder.
- Width is configurable. Tree topology is selectable. Adds subtract mode, a 3-stage pipeline with valid/ready flow control, and status flags (carry, overflow, zero, negative).
- Sits between the operand-select mux and the ALU result mux.

---
 rtl/prefix_addsub_pipe.sv | 134 +++++++++++++
 tb/tb_prefix_addsub_pipe.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_addsub_pipe.sv
// rtl/prefix_addsub_pipe.sv - pipelined parallel-prefix adder/subtractor with valid/ready flow control
module prefix_addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int TREE  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int L = $clog2(WIDTH);
    localparam int H = (L + 1) / 2;

    logic adv;
    logic v1, v2, v3;

    assign adv       = ~v3 | out_ready;
    assign in_ready  = adv;
    assign out_valid = v3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    // Stage 1: operand capture, subtract inversion applied before the register
    logic [WIDTH-1:0] s1_a, s1_bb;
    logic             s1_cin;

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_a   <= a;
            s1_bb  <= sub ? ~b : b;
            s1_cin <= cin;
        end
    end

    logic [WIDTH-1:0] hp, g0;
    assign hp = s1_a ^ s1_bb;
    assign g0 = s1_a & s1_bb;

    logic [WIDTH-1:0] gl  [0:L];
    logic [WIDTH-1:0] pl  [0:L-1];
    logic [WIDTH-1:0] gin [1:L];
    logic [WIDTH-1:0] pin [1:L];

    // Carry-in folded into bit 0's generate so the tree needs only log2(WIDTH) levels
    assign gl[0] = {g0[WIDTH-1:1], g0[0] | (hp[0] & s1_cin)};
    assign pl[0] = hp;

    // Stage 2 registers split the prefix tree roughly in half
    logic [WIDTH-1:0] s2_g, s2_p, s2_hp;
    logic             s2_cin, s2_am, s2_bm;

    always_ff @(posedge clk) begin
        if (adv) begin
            s2_g   <= gl[H];
            s2_p   <= pl[H];
            s2_hp  <= hp;
            s2_cin <= s1_cin;
            s2_am  <= s1_a[WIDTH-1];
            s2_bm  <= s1_bb[WIDTH-1];
        end
    end

    for (genvar lv = 1; lv <= L; lv++) begin : g_lvl
        if (lv == H + 1) begin : g_src_reg
            assign gin[lv] = s2_g;
            assign pin[lv] = s2_p;
        end else begin : g_src_comb
            assign gin[lv] = gl[lv-1];
            assign pin[lv] = pl[lv-1];
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            localparam int D   = 1 << (lv - 1);
            localparam int J   = (TREE == 1) ? (i - D) : (((i >> (lv - 1)) << (lv - 1)) - 1);
            localparam bit ACT = (TREE == 1) ? (i >= D) : (((i >> (lv - 1)) & 1) == 1);

            if (ACT) begin : g_cell
                assign gl[lv][i] = gin[lv][i] | (pin[lv][i] & gin[lv][J]);
                if (lv < L) begin : g_p
                    assign pl[lv][i] = pin[lv][i] & pin[lv][J];
                end
            end else begin : g_pass
                assign gl[lv][i] = gin[lv][i];
                if (lv < L) begin : g_p
                    assign pl[lv][i] = pin[lv][i];
                end
            end
        end
    end

    logic [WIDTH-1:0] carry, sum;
    assign carry = {gl[L][WIDTH-2:0], s2_cin};
    assign sum   = s2_hp ^ carry;

    // Stage 3 is reset so outputs read as zero while idle after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
            neg  <= 1'b0;
        end else if (adv) begin
            s    <= sum;
            cout <= gl[L][WIDTH-1];
            ovf  <= (s2_am == s2_bm) && (sum[WIDTH-1] != s2_am);
            zero <= ~|sum;
            neg  <= sum[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// tb/tb_prefix_addsub_pipe.sv - self-checking bench for prefix_addsub_pipe
module tb_prefix_addsub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, out_ready, cin, sub;
    logic [31:0] a, b;
    logic        in_ready, out_valid, cout, ovf, zero, neg;
    logic [31:0] s;

    int checks   = 0;
    int failures = 0;

    prefix_addsub_pipe #(.WIDTH(32), .TREE(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
    );

    logic        r_valid, r_cin, r_sub;
    logic [63:0] r_a, r_b;
    logic [63:0] rs  [0:5];
    logic [3:0]  rf  [0:5];
    logic        rv  [0:5];
    logic        rir [0:5];

    for (genvar k = 0; k < 6; k++) begin : g_cfg
        localparam int W = (k < 2) ? 8 : (k < 4) ? 16 : 64;
        logic [W-1:0] ss;
        logic co, ov, ze, ne, vo, ir;
        prefix_addsub_pipe #(.WIDTH(W), .TREE(k % 2)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(r_valid), .in_ready(ir),
            .a(r_a[W-1:0]), .b(r_b[W-1:0]), .cin(r_cin), .sub(r_sub),
            .out_valid(vo), .out_ready(1'b1),
            .s(ss), .cout(co), .ovf(ov), .zero(ze), .neg(ne)
        );
        assign rs[k]  = 64'(ss);
        assign rf[k]  = {ze, ne, ov, co};
        assign rv[k]  = vo;
        assign rir[k] = ir;
    end

    function automatic int width_of(input int k);
        return (k < 2) ? 8 : (k < 4) ? 16 : 64;
    endfunction

    // Returns {zero, neg, ovf, cout, s[63:0]} for a WIDTH=w adder
    function automatic logic [67:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                          input logic ci, input logic sb);
        logic [64:0] full;
        logic [63:0] m, xm, bb, sm;
        logic        co, ov;
        m    = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        xm   = x & m;
        bb   = (sb ? ~y : y) & m;
        full = {1'b0, xm} + {1'b0, bb} + {64'd0, ci};
        sm   = full[63:0] & m;
        co   = full[w];
        ov   = (xm[w-1] == bb[w-1]) && (sm[w-1] != xm[w-1]);
        return {(sm == 64'd0), sm[w-1], ov, co, sm};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
        a = '0; b = '0;
        r_valid = 1'b0; r_cin = 1'b0; r_sub = 1'b0; r_a = '0; r_b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL reset_handshake: got valid/ready=%b%b expected 01", out_valid, in_ready);
        end
        checks++;
        if ({s, cout, ovf, zero, neg} !== 36'd0) begin
            failures++;
            $display("FAIL reset_outputs: got s=%h flags=%b%b%b%b expected all zero", s, cout, ovf, zero, neg);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [0:5];
        logic [31:0] tb [0:5];
        logic        tc [0:5];
        logic        tsb[0:5];
        logic [31:0] es [0:5];
        logic [3:0]  ef [0:5];
        int lat;
        ta[0] = 32'hFFFFFFFF; tb[0] = 32'h00000001; tc[0] = 0; tsb[0] = 0; es[0] = 32'h00000000; ef[0] = 4'b1001;
        ta[1] = 32'h7FFFFFFF; tb[1] = 32'h00000001; tc[1] = 0; tsb[1] = 0; es[1] = 32'h80000000; ef[1] = 4'b0110;
        ta[2] = 32'h00000005; tb[2] = 32'h00000007; tc[2] = 1; tsb[2] = 1; es[2] = 32'hFFFFFFFE; ef[2] = 4'b0100;
        ta[3] = 32'h80000000; tb[3] = 32'h00000001; tc[3] = 1; tsb[3] = 1; es[3] = 32'h7FFFFFFF; ef[3] = 4'b0011;
        ta[4] = 32'h00001234; tb[4] = 32'h00001234; tc[4] = 1; tsb[4] = 1; es[4] = 32'h00000000; ef[4] = 4'b1001;
        ta[5] = 32'h00000000; tb[5] = 32'h00000000; tc[5] = 0; tsb[5] = 1; es[5] = 32'hFFFFFFFF; ef[5] = 4'b0100;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = ta[i]; b = tb[i]; cin = tc[i]; sub = tsb[i];
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if (lat !== 3) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d cycles expected 3", i, lat);
            end
            checks++;
            if (s !== es[i]) begin
                failures++;
                $display("FAIL directed_s[%0d]: got %h expected %h", i, s, es[i]);
            end
            checks++;
            if ({zero, neg, ovf, cout} !== ef[i]) begin
                failures++;
                $display("FAIL directed_flags[%0d]: got zno c=%b expected %b", i, {zero, neg, ovf, cout}, ef[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] oa [0:99];
        logic [31:0] ob [0:99];
        logic        oc [0:99];
        logic        os [0:99];
        logic [67:0] e;
        for (int i = 0; i < 100; i++) begin
            oa[i] = $urandom(); ob[i] = $urandom();
            oc[i] = 1'($urandom_range(0, 1)); os[i] = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        for (int n = 0; n < 103; n++) begin
            @(posedge clk); #1;
            if (n >= 3) begin
                e = model(32, {32'd0, oa[n-3]}, {32'd0, ob[n-3]}, oc[n-3], os[n-3]);
                checks++;
                if ({out_valid, zero, neg, ovf, cout, s} !== {1'b1, e[67:64], e[31:0]}) begin
                    failures++;
                    $display("FAIL stream[%0d]: got v=%b f=%b s=%h expected v=1 f=%b s=%h",
                             n - 3, out_valid, {zero, neg, ovf, cout}, s, e[67:64], e[31:0]);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_fill[%0d]: got out_valid=%b expected 0", n, out_valid);
                end
            end
            if (n < 100) begin
                in_valid = 1'b1; a = oa[n]; b = ob[n]; cin = oc[n]; sub = os[n];
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] q[$];
        logic [31:0] prev_s, exp_s;
        logic [67:0] e;
        logic        prev_stall;
        int k, got, n;
        k = 0; got = 0; n = 0; prev_stall = 1'b0; prev_s = '0;
        while (!(k == 12 && got == 12) && n < 60) begin
            @(posedge clk); #1;
            out_ready = !(n >= 6 && n <= 10);
            #1;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || s !== prev_s) begin
                    failures++;
                    $display("FAIL bp_hold[%0d]: got v=%b s=%h expected v=1 s=%h", n, out_valid, s, prev_s);
                end
            end
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_in_ready[%0d]: got %b expected 0", n, in_ready);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL bp_extra[%0d]: got s=%h expected no result", n, s);
                end else begin
                    exp_s = q.pop_front();
                    got++;
                    if (s !== exp_s) begin
                        failures++;
                        $display("FAIL bp_order[%0d]: got s=%h expected %h", n, s, exp_s);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_s = s;
            if (k < 12) begin
                in_valid = 1'b1; a = 32'h01010101 * k; b = k + 3; cin = 1'b0; sub = 1'b0;
                if (in_ready) begin
                    e = model(32, {32'd0, a}, {32'd0, b}, 1'b0, 1'b0);
                    q.push_back(e[31:0]);
                    k++;
                end
            end else begin
                in_valid = 1'b0;
            end
            n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got !== 12 || k !== 12) begin
            failures++;
            $display("FAIL bp_count: got sent=%0d received=%0d expected 12/12", k, got);
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = 32'h100 + i; b = 32'h2; cin = 1'b0; sub = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_full: got out_valid=%b expected 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, s, cout, ovf, zero, neg} !== {2'b01, 36'd0}) begin
            failures++;
            $display("FAIL midrst_async: got v=%b r=%b s=%h flags=%b%b%b%b expected v=0 r=1 zeros",
                     out_valid, in_ready, s, cout, ovf, zero, neg);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL midrst_stale[%0d]: got out_valid=%b expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_param_regression();
        logic [63:0] va [0:39];
        logic [63:0] vb [0:39];
        logic        vc [0:39];
        logic        vs [0:39];
        logic [67:0] e;
        for (int i = 0; i < 40; i++) begin
            va[i] = {$urandom(), $urandom()}; vb[i] = {$urandom(), $urandom()};
            vc[i] = 1'($urandom_range(0, 1)); vs[i] = 1'($urandom_range(0, 1));
        end
        vb[0] = va[0];     vc[0] = 1; vs[0] = 1;
        va[1] = '0;        vc[1] = 1; vs[1] = 1;
        vb[2] = '0;        vc[2] = 1; vs[2] = 1;
        va[3] = '0; vb[3] = '0; vc[3] = 1; vs[3] = 1;
        va[4] = '1; vb[4] = '0; vc[4] = 1; vs[4] = 0;
        vb[5] = '0;        vc[5] = 1; vs[5] = 0;
        va[6] = '1; vb[6] = '1; vc[6] = 1; vs[6] = 0;
        vc[7] = 0; vs[7] = 1;
        for (int n = 0; n < 43; n++) begin
            @(posedge clk); #1;
            if (n >= 3) begin
                for (int k = 0; k < 6; k++) begin
                    e = model(width_of(k), va[n-3], vb[n-3], vc[n-3], vs[n-3]);
                    checks++;
                    if ({rv[k], rir[k], rf[k], rs[k]} !== {2'b11, e}) begin
                        failures++;
                        $display("FAIL param_w%0d_t%0d[%0d]: got v=%b r=%b f=%b s=%h expected v=1 r=1 f=%b s=%h",
                                 width_of(k), k % 2, n - 3, rv[k], rir[k], rf[k], rs[k], e[67:64], e[63:0]);
                    end
                end
            end
            if (n < 40) begin
                r_valid = 1'b1; r_a = va[n]; r_b = vb[n]; r_cin = vc[n]; r_sub = vs[n];
            end else begin
                r_valid = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_param_regression();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
